// File: rtl/matmul_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : matmul_scheduler_if
// Description : Loader and element-engine handshake bundle for the matrix
//               multiply scheduler.
//               Loader channel : req_valid/req_row/req_col out,
//                                rows_valid/rows_row/rows_col back (echo).
//               Engine channel : pe_start out, pe_done back.
//               master = scheduler side, slave = loader/engine side.
// Revision    : 1.0 - initial release
// ============================================================================
interface matmul_scheduler_if #(
    parameter int MAX_SIZE_A = 32,
    parameter int MAX_SIZE_B = 32
);
    localparam int AW = $clog2(MAX_SIZE_A);
    localparam int BW = $clog2(MAX_SIZE_B);

    logic          req_valid;
    logic [AW-1:0] req_row;
    logic [BW-1:0] req_col;
    logic          rows_valid;
    logic [AW-1:0] rows_row;
    logic [BW-1:0] rows_col;
    logic          pe_start;
    logic          pe_done;

    modport master (
        output req_valid, req_row, req_col, pe_start,
        input  rows_valid, rows_row, rows_col, pe_done
    );

    modport slave (
        input  req_valid, req_row, req_col, pe_start,
        output rows_valid, rows_row, rows_col, pe_done
    );
endinterface
`default_nettype wire

// File: rtl/matmul_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : matmul_scheduler
// Description : Walks every (row, col) pair of an A x B product, fetching the
//               operand row/column from a loader and launching one element
//               computation per pair, with per-wait timeout protection.
// Ports       : clk, rstn (async, active-low)
//               start, rows_a, cols_b, load_complete : job request
//               bus (matmul_scheduler_if.master)     : loader + engine
//               busy, done (pulse), error (sticky), elems_done
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_scheduler #(
    parameter int MAX_SIZE_A = 32,
    parameter int MAX_SIZE_B = 32,
    parameter int TIMEOUT    = 1024,
    localparam int AW = $clog2(MAX_SIZE_A),
    localparam int BW = $clog2(MAX_SIZE_B)
) (
    input  wire logic                clk,
    input  wire logic                rstn,
    input  wire logic                start,
    input  wire logic [AW:0]         rows_a,
    input  wire logic [BW:0]         cols_b,
    input  wire logic                load_complete,
    matmul_scheduler_if.master       bus,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [AW+BW:0]           elems_done
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [2:0] c_IDLE        = 3'd0;
    localparam logic [2:0] c_REQ         = 3'd1;
    localparam logic [2:0] c_WAIT_DATA   = 3'd2;
    localparam logic [2:0] c_COMPUTE     = 3'd3;
    localparam logic [2:0] c_WAIT_RESULT = 3'd4;
    localparam logic [2:0] c_FINISH      = 3'd5;
    localparam logic [2:0] c_ERROR       = 3'd6;

    localparam logic [AW:0]   c_MAX_A    = (AW+1)'(MAX_SIZE_A);
    localparam logic [BW:0]   c_MAX_B    = (BW+1)'(MAX_SIZE_B);
    localparam logic [TW-1:0] c_TMO_LAST = TW'(TIMEOUT - 1);

    logic [2:0]     r_state;
    logic [AW:0]    r_rows_a;
    logic [BW:0]    r_cols_b;
    logic [AW-1:0]  r_row;
    logic [BW-1:0]  r_col;
    logic [AW+BW:0] r_elems;
    logic [TW-1:0]  r_wait;
    logic           r_error;

    logic w_start_ok;
    logic w_echo_ok;
    logic w_last_col;
    logic w_last_row;

    assign w_start_ok = load_complete
                        && (rows_a != '0) && (rows_a <= c_MAX_A)
                        && (cols_b != '0) && (cols_b <= c_MAX_B);
    assign w_echo_ok  = (bus.rows_row == r_row) && (bus.rows_col == r_col);
    assign w_last_col = ({1'b0, r_col} == (r_cols_b - 1'b1));
    assign w_last_row = ({1'b0, r_row} == (r_rows_a - 1'b1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= c_IDLE;
            r_rows_a <= '0;
            r_cols_b <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_elems  <= '0;
            r_wait   <= '0;
            r_error  <= 1'b0;
        end else begin
            case (r_state)
                // ERROR accepts a new job exactly like IDLE does
                c_IDLE, c_ERROR: begin
                    if (start) begin
                        if (w_start_ok) begin
                            r_rows_a <= rows_a;
                            r_cols_b <= cols_b;
                            r_row    <= '0;
                            r_col    <= '0;
                            r_elems  <= '0;
                            r_error  <= 1'b0;
                            r_state  <= c_REQ;
                        end else begin
                            r_error  <= 1'b1;
                            r_state  <= c_ERROR;
                        end
                    end
                end
                c_REQ: begin
                    r_wait  <= '0;
                    r_state <= c_WAIT_DATA;
                end
                c_WAIT_DATA: begin
                    // awaited input takes priority over timeout expiry
                    if (bus.rows_valid) begin
                        if (w_echo_ok) begin
                            r_state <= c_COMPUTE;
                        end else begin
                            r_error <= 1'b1;
                            r_state <= c_ERROR;
                        end
                    end else if (r_wait == c_TMO_LAST) begin
                        r_error <= 1'b1;
                        r_state <= c_ERROR;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                c_COMPUTE: begin
                    r_wait  <= '0;
                    r_state <= c_WAIT_RESULT;
                end
                c_WAIT_RESULT: begin
                    if (bus.pe_done) begin
                        r_elems <= r_elems + 1'b1;
                        // the final pair is kept so the address outputs
                        // never step past the matrix bounds
                        if (w_last_col && w_last_row) begin
                            r_state <= c_FINISH;
                        end else if (w_last_col) begin
                            r_col   <= '0;
                            r_row   <= r_row + 1'b1;
                            r_state <= c_REQ;
                        end else begin
                            r_col   <= r_col + 1'b1;
                            r_state <= c_REQ;
                        end
                    end else if (r_wait == c_TMO_LAST) begin
                        r_error <= 1'b1;
                        r_state <= c_ERROR;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                c_FINISH: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Outputs decode straight from registers so an asynchronous reset
    // clears them without waiting for a clock edge.
    assign bus.req_valid = (r_state == c_REQ);
    assign bus.req_row   = (r_state == c_IDLE) ? '0 : r_row;
    assign bus.req_col   = (r_state == c_IDLE) ? '0 : r_col;
    assign bus.pe_start  = (r_state == c_COMPUTE);
    assign done          = (r_state == c_FINISH);
    assign busy          = (r_state == c_REQ) || (r_state == c_WAIT_DATA)
                           || (r_state == c_COMPUTE) || (r_state == c_WAIT_RESULT)
                           || (r_state == c_FINISH);
    assign error         = r_error;
    assign elems_done    = r_elems;

endmodule
`default_nettype wire

// File: tb/tb_matmul_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_matmul_scheduler
// Description : Self-checking bench for matmul_scheduler. Expected request
//               pairs are queued when a job is launched and compared as the
//               scheduler issues them; loader and engine are behavioural
//               responders with adjustable latency and fault injection.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matmul_scheduler;

    localparam int MA  = 32;
    localparam int MB  = 32;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        load_complete = 1'b0;
    logic [5:0]  rows_a = '0;
    logic [5:0]  cols_b = '0;
    logic        busy;
    logic        done;
    logic        error;
    logic [10:0] elems_done;

    matmul_scheduler_if #(.MAX_SIZE_A(MA), .MAX_SIZE_B(MB)) bus ();

    matmul_scheduler #(
        .MAX_SIZE_A (MA),
        .MAX_SIZE_B (MB),
        .TIMEOUT    (TMO)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .start         (start),
        .rows_a        (rows_a),
        .cols_b        (cols_b),
        .load_complete (load_complete),
        .bus           (bus.master),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .elems_done    (elems_done)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         done_cnt = 0;
    int         n_unexp  = 0;
    logic [9:0] sb_q[$];
    logic [9:0] mon_exp;
    int         lat_data = 3;
    int         lat_pe   = 5;
    bit         corrupt  = 1'b0;
    bit         withhold = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // request monitor / done counter
    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
            if (bus.req_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_unexp++;
                end else begin
                    mon_exp = sb_q.pop_front();
                    chk("req_pair", {22'd0, bus.req_row, bus.req_col}, {22'd0, mon_exp});
                end
            end
        end
    end

    // loader responder: echoes the requested pair after lat_data cycles
    initial begin : loader
        logic [4:0] rr;
        logic [4:0] cc;
        bus.rows_valid = 1'b0;
        bus.rows_row   = '0;
        bus.rows_col   = '0;
        forever begin
            @(negedge clk);
            if (bus.req_valid === 1'b1) begin
                rr = bus.req_row;
                cc = bus.req_col;
                repeat (lat_data) @(negedge clk);
                bus.rows_valid = 1'b1;
                bus.rows_row   = rr;
                bus.rows_col   = (corrupt && cc == 5'd1) ? 5'd2 : cc;
                @(negedge clk);
                bus.rows_valid = 1'b0;
            end
        end
    end

    // element engine responder
    initial begin
        bus.pe_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.pe_start === 1'b1) begin
                repeat (lat_pe) @(negedge clk);
                if (!withhold) begin
                    bus.pe_done = 1'b1;
                    @(negedge clk);
                    bus.pe_done = 1'b0;
                end
            end
        end
    end

    task automatic push_pairs(input int r, input int c, input int n);
        int k = 0;
        for (int i = 0; i < r; i++)
            for (int j = 0; j < c; j++) begin
                if (k < n) sb_q.push_back({i[4:0], j[4:0]});
                k++;
            end
    endtask

    task automatic pulse_start(input int r, input int c, input bit lc);
        rows_a        = r[5:0];
        cols_b        = c[5:0];
        load_complete = lc;
        start         = 1'b1;
        @(negedge clk);
        start         = 1'b0;
    endtask

    task automatic wait_sig_done(input string tag, input int budget);
        int cyc = 0;
        while (done !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_done_seen"}, done, 1);
    endtask

    task automatic wait_error(input string tag, input int budget);
        int cyc = 0;
        while (error !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_error"}, error, 1);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic run_job(input string tag, input int r, input int c,
                           input int budget, input bit poke);
        done_cnt = 0;
        push_pairs(r, c, r * c);
        pulse_start(r, c, 1'b1);
        chk({tag, "_req_lat"}, bus.req_valid, 1);
        chk({tag, "_err_clr"}, error, 0);
        if (poke) begin
            repeat (8) @(negedge clk);
            pulse_start(0, 0, 1'b1);   // must be ignored while busy
        end
        wait_sig_done(tag, budget);
        repeat (3) @(negedge clk);
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_elems"}, elems_done, r * c);
        chk({tag, "_q_empty"}, sb_q.size(), 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_error"}, error, 0);
    endtask

    initial begin : main
        int cyc;
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_elems", elems_done, 0);
        chk("rst_req_valid", bus.req_valid, 0);
        chk("rst_pe_start", bus.pe_start, 0);
        rstn = 1'b1;
        @(negedge clk);

        // 2x3 nominal job with an ignored mid-job start
        run_job("job2x3", 2, 3, 500, 1'b1);

        // illegal starts: nothing latched, no requests
        pulse_start(0, 1, 1'b1);
        chk("ill_rows0_err", error, 1);
        chk("ill_rows0_busy", busy, 0);
        repeat (5) @(negedge clk);
        chk("ill_keep_elems", elems_done, 6);
        pulse_start(1, 33, 1'b1);
        chk("ill_cols33_err", error, 1);
        pulse_start(1, 1, 1'b0);
        chk("ill_noload_err", error, 1);
        chk("ill_no_req", n_unexp, 0);
        run_job("recover1x1", 1, 1, 200, 1'b0);

        // echo mismatch on pair (0,1)
        corrupt  = 1'b1;
        done_cnt = 0;
        push_pairs(2, 2, 2);
        pulse_start(2, 2, 1'b1);
        wait_error("echo", 200);
        repeat (20) @(negedge clk);
        chk("echo_no_more_req", n_unexp, 0);
        chk("echo_q_empty", sb_q.size(), 0);
        chk("echo_no_done", done_cnt, 0);
        corrupt = 1'b0;

        // result timeout with pe_done withheld
        withhold = 1'b1;
        push_pairs(1, 1, 1);
        pulse_start(1, 1, 1'b1);
        cyc = 0;
        while (bus.pe_start !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("tmo_pe_start", bus.pe_start, 1);
        repeat (16) @(negedge clk);
        chk("tmo_c15_error", error, 0);
        chk("tmo_c15_busy", busy, 1);
        @(negedge clk);
        chk("tmo_expired_error", error, 1);
        chk("tmo_expired_busy", busy, 0);
        withhold = 1'b0;
        repeat (10) @(negedge clk);

        // pe_done on the expiry cycle wins
        lat_pe = 16;
        run_job("tmo_edge", 1, 1, 300, 1'b0);
        // one cycle later is too late
        lat_pe = 17;
        push_pairs(1, 1, 1);
        pulse_start(1, 1, 1'b1);
        wait_error("tmo_late", 100);
        repeat (30) @(negedge clk);
        lat_pe = 5;

        // asynchronous reset in WAIT_DATA of the second element of a 4x4 job
        done_cnt = 0;
        push_pairs(4, 4, 16);
        pulse_start(4, 4, 1'b1);
        cyc = 0;
        while (!(bus.req_valid === 1'b1 && bus.req_col == 5'd1) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        chk("mid_busy", busy, 1);
        chk("mid_req_col", bus.req_col, 1);
        chk("mid_elems", elems_done, 1);
        rstn = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_req_col", bus.req_col, 0);
        chk("arst_elems", elems_done, 0);
        chk("arst_req_valid", bus.req_valid, 0);
        chk("arst_pe_start", bus.pe_start, 0);
        chk("arst_error", error, 0);
        sb_q.delete();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (40) @(negedge clk);
        chk("arst_no_done", done_cnt, 0);
        chk("arst_no_req", n_unexp, 0);
        run_job("post_rst1x1", 1, 1, 200, 1'b0);

        // full-size job
        lat_data = 1;
        lat_pe   = 1;
        run_job("big32x32", 32, 32, 30000, 1'b0);
        chk("final_no_unexp", n_unexp, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/matmul_scheduler.md
MATMUL_SCHEDULER -- requirements
Module: matmul_scheduler

Interface
REQ-001 Parameter MAX_SIZE_A, default 32, SHALL be the maximum rows of A (row address width AW = $clog2(MAX_SIZE_A)).
REQ-002 Parameter MAX_SIZE_B, default 32, SHALL be the maximum columns of B (column address width BW = $clog2(MAX_SIZE_B)).
REQ-003 Parameter TIMEOUT, default 1024, SHALL be the wait-state cycle limit before error.
REQ-004 Clocking: a single clock domain; reset is asynchronous and active-low.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rstn  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  single-cycle job start request.
REQ-008 rows_a  in  AW+1  rows of A in the job, legal 1..MAX_SIZE_A.
REQ-009 cols_b  in  BW+1  columns of B in the job, legal 1..MAX_SIZE_B.
REQ-010 load_complete  in  1  loader holds both matrices; level.
REQ-011 req_valid  out  1  one-cycle row/column fetch request.
REQ-012 req_row  out  AW  requested A row; req_col  out  BW  requested B column.
REQ-013 rows_valid  in  1  loader data valid; rows_row (AW) and rows_col (BW) echo the fetched addresses.
REQ-014 pe_start  out  1  one-cycle compute start to the element engine.
REQ-015 pe_done  in  1  element engine result-valid pulse.
REQ-016 busy  out  1; done  out  1 (one-cycle pulse); error  out  1 (sticky); elems_done  out  AW+BW+1 (completed element count).

Function
REQ-017 States SHALL be IDLE, REQ, WAIT_DATA, COMPUTE, WAIT_RESULT, FINISH, ERROR.
REQ-018 IDLE: start=1 with load_complete=1 and legal dims SHALL latch rows_a/cols_b, clear row/col/elems_done/error, and go to REQ.
REQ-019 IDLE: start=1 with illegal dims (0 or >MAX) or load_complete=0 SHALL set error, go to ERROR, and latch nothing.
REQ-020 REQ: req_valid=1 for exactly one cycle with current row/col; next state WAIT_DATA (start at cycle N -> req_valid at N+1).
REQ-021 req_row/req_col SHALL hold the current pair in all non-IDLE states.
REQ-022 WAIT_DATA: rows_valid=1 with echo matching current pair -> COMPUTE; mismatch -> ERROR.
REQ-023 COMPUTE: pe_start=1 for one cycle; next state WAIT_RESULT.
REQ-024 WAIT_RESULT: pe_done=1 SHALL increment elems_done and advance col; when col = cols_b-1, col wraps to 0 and row increments.
REQ-025 On pe_done for pair (rows_a-1, cols_b-1) -> FINISH; otherwise -> REQ.
REQ-026 FINISH: done=1 for one cycle; next state IDLE; elems_done holds rows_a*cols_b until the next accepted start.
REQ-027 A wait counter SHALL clear on entry to WAIT_DATA/WAIT_RESULT; reaching TIMEOUT-1 without the awaited input -> ERROR.
REQ-028 An awaited input arriving in the same cycle as timeout expiry SHALL win (no error).
REQ-029 rows_valid outside WAIT_DATA and pe_done outside WAIT_RESULT SHALL be ignored.
REQ-030 start outside IDLE/ERROR SHALL be ignored.
REQ-031 ERROR: error=1, busy=0, no requests issued; a legal start (REQ-018 conditions) SHALL clear error and go to REQ.
REQ-032 busy SHALL be 1 in REQ, WAIT_DATA, COMPUTE, WAIT_RESULT, FINISH; 0 in IDLE and ERROR.
REQ-033 elems_done SHALL be wide enough for MAX_SIZE_A*MAX_SIZE_B without overflow.

Reset
REQ-034 rstn=0 SHALL asynchronously force IDLE and zero every output, counter and latched dimension.
REQ-035 Reset mid-job SHALL abandon the job; no done pulse after rstn rises; the first start after reset behaves as from power-up.

Verification
REQ-036 2x3 job, loader echoes correctly after 3 cycles, pe_done after 5 cycles -> 6 req_valid pulses in order (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); one done pulse; elems_done=6.
REQ-037 rows_a=0 or cols_b=33 with start -> error=1, no req_valid; a following legal 1x1 start -> error=0, done after one element.
REQ-038 Echo rows_col=2 while requesting (0,1) -> ERROR state, error=1, busy=0.
REQ-039 TIMEOUT=16, pe_done withheld -> error on cycle 15 after entering WAIT_RESULT; pe_done on cycle 15 instead -> no error.
REQ-040 rstn pulsed low during WAIT_DATA of a 4x4 job -> all outputs 0 immediately; no done; new 1x1 job completes normally.
REQ-041 32x32 job -> 1024 requests, row/col wrap correct, elems_done=1024, single done pulse.
